// File: rtl/icache_axi_rd_bridge.sv
// Read-only AXI master for the icache miss port: one AR burst per request,
// R beats gathered into a 128-bit line and returned as a single ret_valid pulse.
module icache_axi_rd_bridge #(
    parameter logic [3:0] ARID_VAL = 4'd0
) (
    input  logic         clk,
    input  logic         resetn,
    // cache side
    input  logic         rd_req,
    input  logic [2:0]   rd_type,
    input  logic [31:0]  rd_addr,
    output logic         rd_rdy,
    output logic         ret_valid,
    output logic [127:0] ret_data,
    // AXI read address channel
    output logic [3:0]   arid,
    output logic [31:0]  araddr,
    output logic [7:0]   arlen,
    output logic [2:0]   arsize,
    output logic [1:0]   arburst,
    output logic [1:0]   arlock,
    output logic [3:0]   arcache,
    output logic [2:0]   arprot,
    output logic         arvalid,
    input  logic         arready,
    // AXI read data channel
    input  logic [3:0]   rid,
    input  logic [31:0]  rdata,
    input  logic [1:0]   rresp,
    input  logic         rlast,
    input  logic         rvalid,
    output logic         rready
);

    localparam int unsigned WORD_W = 32;
    localparam int unsigned LANES  = 4;
    localparam int unsigned CNT_W  = 2;

    localparam logic [2:0]       TYPE_LINE = 3'b100;
    localparam logic [7:0]       LEN_LINE  = 8'd3;
    localparam logic [7:0]       LEN_WORD  = 8'd0;
    localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(LANES - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_AR   = 2'd1,
        S_R    = 2'd2,
        S_RET  = 2'd3
    } state_t;

    state_t                         state;
    state_t                         state_nx;
    logic [CNT_W-1:0]               beat_cnt;
    logic [LANES-1:0][WORD_W-1:0]   line_q;
    logic                           ar_entry_c;
    logic                           beat_acc_c;
    logic                           unused_c;

    // Fixed AR attributes: 4-byte beats, INCR, normal non-cacheable access.
    assign arid     = ARID_VAL;
    assign arsize   = 3'b010;
    assign arburst  = 2'b01;
    assign arlock   = 2'b00;
    assign arcache  = 4'b0000;
    assign arprot   = 3'b000;
    assign ret_data = line_q;

    // rid and rresp are deliberately not checked; data is returned as received.
    assign unused_c = ^{rid, rresp};

    assign ar_entry_c = (state == S_IDLE) & rd_req;
    assign beat_acc_c = (state == S_R) & rvalid & rready;

    // Next-state logic.
    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:  if (rd_req)                   state_nx = S_AR;
            S_AR:    if (arvalid & arready)        state_nx = S_R;
            S_R:     if (beat_acc_c & rlast)       state_nx = S_RET;
            S_RET:                                 state_nx = S_IDLE;
            default:                               state_nx = S_IDLE;
        endcase
    end

    // State, registered handshake outputs, AR fields and line buffer.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state     <= S_IDLE;
            rd_rdy    <= 1'b1;
            arvalid   <= 1'b0;
            rready    <= 1'b0;
            ret_valid <= 1'b0;
            araddr    <= '0;
            arlen     <= '0;
            beat_cnt  <= '0;
            line_q    <= '0;
        end else begin
            state     <= state_nx;
            rd_rdy    <= (state_nx == S_IDLE);
            arvalid   <= (state_nx == S_AR);
            rready    <= (state_nx == S_R);
            ret_valid <= (state_nx == S_RET);

            if (ar_entry_c) begin
                araddr   <= rd_addr;
                arlen    <= (rd_type == TYPE_LINE) ? LEN_LINE : LEN_WORD;
                beat_cnt <= '0;
                line_q   <= '0;
            end

            // Beats past the fourth keep landing in the top lane.
            if (beat_acc_c) begin
                line_q[beat_cnt] <= rdata;
                if (beat_cnt != CNT_MAX) begin
                    beat_cnt <= beat_cnt + CNT_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_icache_axi_rd_bridge.sv
// Directed bench for icache_axi_rd_bridge: a table of read transactions run
// through a small AXI slave model, plus reset and back-to-back sequences.
module tb_icache_axi_rd_bridge;

    logic         clk;
    logic         resetn;
    logic         rd_req;
    logic [2:0]   rd_type;
    logic [31:0]  rd_addr;
    logic         rd_rdy;
    logic         ret_valid;
    logic [127:0] ret_data;
    logic [3:0]   arid;
    logic [31:0]  araddr;
    logic [7:0]   arlen;
    logic [2:0]   arsize;
    logic [1:0]   arburst;
    logic [1:0]   arlock;
    logic [3:0]   arcache;
    logic [2:0]   arprot;
    logic         arvalid;
    logic         arready;
    logic [3:0]   rid;
    logic [31:0]  rdata;
    logic [1:0]   rresp;
    logic         rlast;
    logic         rvalid;
    logic         rready;

    int n_tests = 0;
    int n_fail  = 0;

    icache_axi_rd_bridge #(.ARID_VAL(4'd0)) dut (
        .clk(clk), .resetn(resetn),
        .rd_req(rd_req), .rd_type(rd_type), .rd_addr(rd_addr), .rd_rdy(rd_rdy),
        .ret_valid(ret_valid), .ret_data(ret_data),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize),
        .arburst(arburst), .arlock(arlock), .arcache(arcache), .arprot(arprot),
        .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast),
        .rvalid(rvalid), .rready(rready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string        name;
        logic [2:0]   rtype;
        logic [31:0]  addr;
        logic [7:0]   exp_arlen;
        int           nbeats;
        logic [5:0][31:0] beats;
        int           ar_wait;
        bit           toggle;
        logic [127:0] exp_data;
    } vec_t;

    vec_t vecs[7];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Runs one request to completion; called one step after a clock edge while idle.
    task automatic do_txn(input vec_t v);
        int  idx;
        int  cyc;
        bit  done;
        check({v.name, " rd_rdy idle"}, 128'(rd_rdy), 128'(1));
        rd_req  = 1'b1;
        rd_type = v.rtype;
        rd_addr = v.addr;
        tick();
        rd_req  = 1'b0;
        rd_addr = 32'hffff_fff0;
        check({v.name, " arvalid"}, 128'(arvalid), 128'(1));
        check({v.name, " araddr"},  128'(araddr),  128'(v.addr));
        check({v.name, " arlen"},   128'(arlen),   128'(v.exp_arlen));
        check({v.name, " arsize"},  128'(arsize),  128'(3'b010));
        check({v.name, " arburst"}, 128'(arburst), 128'(2'b01));
        check({v.name, " arid"},    128'(arid),    128'(4'd0));
        check({v.name, " rready in AR"}, 128'(rready), 128'(0));
        for (int w = 0; w < v.ar_wait; w++) begin
            arready = 1'b0;
            tick();
            check($sformatf("%s stall%0d arvalid", v.name, w), 128'(arvalid), 128'(1));
            check($sformatf("%s stall%0d araddr",  v.name, w), 128'(araddr),  128'(v.addr));
            check($sformatf("%s stall%0d arlen",   v.name, w), 128'(arlen),   128'(v.exp_arlen));
            check($sformatf("%s stall%0d rd_rdy",  v.name, w), 128'(rd_rdy),  128'(0));
        end
        arready = 1'b1;
        tick();
        arready = 1'b0;
        check({v.name, " arvalid dropped"}, 128'(arvalid), 128'(0));
        idx  = 0;
        cyc  = 0;
        done = 1'b0;
        while (!done && cyc < 40) begin
            if (v.toggle && (cyc % 2) == 1) begin
                rvalid = 1'b0;
                rlast  = 1'b0;
            end else begin
                rvalid = 1'b1;
                rdata  = v.beats[idx];
                rlast  = (idx == v.nbeats - 1);
            end
            check($sformatf("%s rready c%0d", v.name, cyc), 128'(rready), 128'(1));
            tick();
            if (rvalid) begin
                if (rlast) done = 1'b1;
                idx++;
            end
            cyc++;
        end
        rvalid = 1'b0;
        rlast  = 1'b0;
        if (!done) begin
            check({v.name, " burst timeout"}, 128'(0), 128'(1));
            return;
        end
        check({v.name, " ret_valid"},    128'(ret_valid), 128'(1));
        check({v.name, " ret_data"},     ret_data,        v.exp_data);
        check({v.name, " rready in RET"},128'(rready),    128'(0));
        check({v.name, " rd_rdy in RET"},128'(rd_rdy),    128'(0));
        tick();
        check({v.name, " ret_valid pulse"}, 128'(ret_valid), 128'(0));
        check({v.name, " rd_rdy back"},     128'(rd_rdy),    128'(1));
        check({v.name, " ret_data hold"},   ret_data,        v.exp_data);
    endtask

    initial begin
        vec_t v;
        resetn  = 1'b0;
        rd_req  = 1'b0;
        rd_type = 3'b000;
        rd_addr = 32'h0;
        arready = 1'b0;
        rid     = 4'h5;
        rdata   = 32'h0;
        rresp   = 2'b10;
        rlast   = 1'b0;
        rvalid  = 1'b0;

        vecs[0] = '{"line", 3'b100, 32'h1fc0_0040, 8'd3, 4,
                    {32'h0, 32'h0, 32'h44, 32'h33, 32'h22, 32'h11}, 0, 1'b0,
                    {32'h44, 32'h33, 32'h22, 32'h11}};
        vecs[1] = '{"word", 3'b010, 32'hbfaf_8004, 8'd0, 1,
                    {32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'hdeadbeef}, 0, 1'b0,
                    {96'h0, 32'hdeadbeef}};
        vecs[2] = '{"arstall", 3'b100, 32'h0000_1000, 8'd3, 4,
                    {32'h0, 32'h0, 32'hd0d0_0004, 32'hc0c0_0003, 32'hb0b0_0002, 32'ha0a0_0001}, 5, 1'b0,
                    {32'hd0d0_0004, 32'hc0c0_0003, 32'hb0b0_0002, 32'ha0a0_0001}};
        vecs[3] = '{"toggle", 3'b100, 32'h0000_2010, 8'd3, 4,
                    {32'h0, 32'h0, 32'h4444_4444, 32'h3333_3333, 32'h2222_2222, 32'h1111_1111}, 0, 1'b1,
                    {32'h4444_4444, 32'h3333_3333, 32'h2222_2222, 32'h1111_1111}};
        vecs[4] = '{"saturate", 3'b100, 32'h0000_3000, 8'd3, 6,
                    {32'h6, 32'h5, 32'h4, 32'h3, 32'h2, 32'h1}, 0, 1'b0,
                    {32'h6, 32'h3, 32'h2, 32'h1}};
        vecs[5] = '{"early_rlast", 3'b100, 32'h0000_4020, 8'd3, 2,
                    {32'h0, 32'h0, 32'h0, 32'h0, 32'hbb, 32'haa}, 0, 1'b0,
                    {32'h0, 32'h0, 32'hbb, 32'haa}};
        vecs[6] = '{"word_clear", 3'b010, 32'h0000_0004, 8'd0, 1,
                    {32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h77}, 0, 1'b0,
                    {96'h0, 32'h77}};

        // Reset values.
        #12;
        check("rst arvalid",   128'(arvalid),   128'(0));
        check("rst rready",    128'(rready),    128'(0));
        check("rst ret_valid", 128'(ret_valid), 128'(0));
        check("rst rd_rdy",    128'(rd_rdy),    128'(1));
        check("rst ret_data",  ret_data,        128'(0));
        check("rst araddr",    128'(araddr),    128'(0));
        check("rst arlen",     128'(arlen),     128'(0));
        check("rst attrs",     128'({arlock, arcache, arprot}), 128'(0));
        tick();
        resetn = 1'b1;
        tick();
        check("idle rready with rvalid", 128'(rready), 128'(0));

        for (int i = 0; i < 7; i++) begin
            do_txn(vecs[i]);
            tick();
        end

        // Reset after two beats of a line read.
        rd_req  = 1'b1;
        rd_type = 3'b100;
        rd_addr = 32'h0000_5000;
        tick();
        rd_req  = 1'b0;
        arready = 1'b1;
        tick();
        arready = 1'b0;
        rvalid  = 1'b1;
        rdata   = 32'hcafe_0001;
        tick();
        rdata   = 32'hcafe_0002;
        tick();
        check("midrst rready before", 128'(rready), 128'(1));
        #2;
        resetn = 1'b0;
        rvalid = 1'b0;
        #1;
        check("midrst arvalid",   128'(arvalid),   128'(0));
        check("midrst rready",    128'(rready),    128'(0));
        check("midrst ret_valid", 128'(ret_valid), 128'(0));
        check("midrst rd_rdy",    128'(rd_rdy),    128'(1));
        check("midrst ret_data",  ret_data,        128'(0));
        check("midrst araddr",    128'(araddr),    128'(0));
        check("midrst arlen",     128'(arlen),     128'(0));
        tick();
        resetn = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick();
            check($sformatf("postrst c%0d ret_valid", c), 128'(ret_valid), 128'(0));
            check($sformatf("postrst c%0d arvalid", c),   128'(arvalid),   128'(0));
        end
        v = vecs[1];
        v.name = "postrst word";
        v.addr = 32'h0000_0040;
        do_txn(v);
        tick();

        // Back-to-back with rd_req held high throughout.
        rd_req  = 1'b1;
        rd_type = 3'b100;
        rd_addr = 32'h0000_6000;
        tick();
        check("b2b first araddr", 128'(araddr), 128'(32'h0000_6000));
        rd_addr = 32'h0000_7004;
        rd_type = 3'b010;
        arready = 1'b1;
        tick();
        arready = 1'b0;
        for (int b = 0; b < 4; b++) begin
            rvalid = 1'b1;
            rdata  = 32'h6000_0000 + 32'(b);
            rlast  = (b == 3);
            tick();
            if (b < 3) check($sformatf("b2b beat%0d no ret", b), 128'(ret_valid), 128'(0));
        end
        rvalid = 1'b0;
        rlast  = 1'b0;
        check("b2b ret_valid", 128'(ret_valid), 128'(1));
        check("b2b ret_data",  ret_data, {32'h6000_0003, 32'h6000_0002, 32'h6000_0001, 32'h6000_0000});
        tick();
        check("b2b idle rd_rdy",   128'(rd_rdy),  128'(1));
        check("b2b idle arvalid",  128'(arvalid), 128'(0));
        check("b2b idle ret_data", ret_data, {32'h6000_0003, 32'h6000_0002, 32'h6000_0001, 32'h6000_0000});
        tick();
        rd_req = 1'b0;
        check("b2b second arvalid", 128'(arvalid), 128'(1));
        check("b2b second araddr",  128'(araddr),  128'(32'h0000_7004));
        check("b2b second arlen",   128'(arlen),   128'(0));
        check("b2b cleared",        ret_data,      128'(0));
        arready = 1'b1;
        tick();
        arready = 1'b0;
        rvalid  = 1'b1;
        rlast   = 1'b1;
        rdata   = 32'h1234_5678;
        tick();
        rvalid  = 1'b0;
        rlast   = 1'b0;
        check("b2b second ret_valid", 128'(ret_valid), 128'(1));
        check("b2b second ret_data",  ret_data, {96'h0, 32'h1234_5678});
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
